fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit RISC core, sitting directly upstream of the 16-entry instruction memory and downstream-feeding the decoder. Owns the program counter, drives the memory's combinational read address, captures the returned word into an instruction register, and hands it to decode over a valid/ready handshake. Unconditional jumps (opcode 1011) are resolved inside the block with no bubble. Redirects from execute and a halt request are also handled here.

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory combinationally,
// registers the word into ir_out and offers it to decode over valid/ready.
module fetch_unit #(
    parameter int                ADDR_W      = 4,
    parameter int                INSTR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        JUMP_OPCODE = 4'b1011
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               jump_taken,
    output logic [7:0]         fetch_count,
    output logic               dbg_state
);

    // Handshake: a word moves to decode on any cycle where ir_valid && ir_ready are both
    // high at the rising edge; while ir_valid is high and ir_ready low, ir_out/ir_pc/ir_valid
    // stay bit-stable. Redirect flushes whatever was not delivered on that same edge.

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic                valid_q, valid_d;
    logic                jump_q, jump_d;
    logic [7:0]          count_q, count_d;
    logic                load;
    logic                is_jump;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ir_pc_q <= '0;
            valid_q <= 1'b0;
            jump_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
            jump_q  <= jump_d;
            count_q <= count_d;
        end
    end

    assign is_jump = (imem_instr[INSTR_W-1 -: 4] == JUMP_OPCODE);
    assign load    = (state_q == RUN) && !redirect_valid && (!valid_q || ir_ready);

    always_comb begin
        state_d = halt ? HALTED : RUN;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
        jump_d  = 1'b0;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end else if (load) begin
            ir_d    = imem_instr;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            jump_d  = is_jump;
            // Jumps resolve here so the target is fetched on the very next edge.
            pc_d    = is_jump ? imem_instr[ADDR_W-1:0] : pc_q + PC_ONE;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end else if (valid_q && ir_ready) begin
            valid_d = 1'b0;
        end
    end

    assign imem_addr   = pc_q;
    assign ir_out      = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = valid_q;
    assign jump_taken  = jump_q;
    assign fetch_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized control inputs, every cycle
// compared against a transaction-level model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] ir_out;
  logic [3:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_pc = '0;
  logic        halt = 1'b0;
  logic        jump_taken;
  logic [7:0]  fetch_count;
  logic        dbg_state;

  logic [15:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_pc, m_irpc, m_cnt;
  logic [15:0] m_ir;
  bit          m_valid, m_jump, m_halted;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .jump_taken(jump_taken), .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_word(input bit allow_jump);
    logic [15:0] w;
    w = 16'($urandom);
    if (!allow_jump && w[15:12] == 4'hB) w[15:12] = 4'h0;
    if (allow_jump && $urandom_range(0, 3) == 0) w[15:12] = 4'hB;
    return w;
  endfunction

  // Model: what the fetch stage should have done at the coming edge given current inputs.
  task automatic model_step();
    bit can_load;
    if (rst) begin
      m_pc = 0; m_ir = '0; m_irpc = 0; m_valid = 0; m_jump = 0; m_cnt = 0; m_halted = 0;
      exp_q.delete();
      return;
    end
    if (m_valid && ir_ready) begin
      check("delivered", exp_q.size() > 0 ? int'(exp_q[0]) : -1, int'(m_ir));
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    can_load = !m_halted && !redirect_valid && (!m_valid || ir_ready);
    if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 0; m_jump = 0;
      exp_q.delete();
    end else if (can_load) begin
      m_ir = mem[m_pc];
      m_irpc = m_pc;
      m_valid = 1;
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      m_jump = (m_ir[15:12] == 4'hB);
      m_pc = m_jump ? int'(m_ir[3:0]) : (m_pc + 1) % 16;
      exp_q.push_back(m_ir);
    end else begin
      m_jump = 0;
      if (m_valid && ir_ready) m_valid = 0;
    end
    m_halted = halt;
  endtask

  task automatic compare_all();
    check("ir_valid", ir_valid, m_valid);
    check("ir_pc", ir_pc, m_irpc);
    check("ir_out", ir_out, m_ir);
    check("imem_addr", imem_addr, m_pc);
    check("jump_taken", jump_taken, m_jump);
    check("fetch_count", fetch_count, m_cnt);
    check("state", dbg_state, m_halted);
  endtask

  // Inputs are set after the previous tick's #1 sample point, so they are stable at the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; halt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = rand_word(1'b0);

    // reset state
    do_reset();
    check("rst_valid", ir_valid, 0);
    check("rst_count", fetch_count, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_ir", ir_out, 0);
    check("rst_jump", jump_taken, 0);

    // straight line with a jump at 7 back to 0
    for (int i = 0; i < 16; i++) mem[i] = rand_word(1'b0);
    mem[7] = 16'hB000;
    ir_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("seq_pc", ir_pc, (i < 8) ? i : i - 8);
      check("seq_jump", jump_taken, ((i < 8) ? i : i - 8) == 7);
      check("seq_count", fetch_count, i + 1);
    end

    // backpressure while ir_pc == 2
    do_reset();
    tick(); tick(); tick();
    check("bp_pc", ir_pc, 2);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_pc", ir_pc, 2);
      check("bp_hold_addr", imem_addr, 3);
    end
    ir_ready = 1'b1;
    tick();
    check("bp_next", ir_pc, 3);

    // redirect while ir_pc == 1
    do_reset();
    tick(); tick();
    check("rd_pc", ir_pc, 1);
    redirect_valid = 1'b1; redirect_pc = 4'd5;
    tick();
    redirect_valid = 1'b0;
    check("rd_flush", ir_valid, 0);
    tick();
    check("rd_target", ir_pc, 5);
    check("rd_word", ir_out, mem[5]);

    // wrap without jumps
    for (int i = 0; i < 16; i++) mem[i] = rand_word(1'b0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 15) check("wrap_15", ir_pc, 15);
    end
    check("wrap_0", ir_pc, 0);
    check("wrap_count", fetch_count, 17);

    // halt for 4 cycles
    halt = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("halt_valid", ir_valid, 0);
    check("halt_addr", imem_addr, 2);
    halt = 1'b0;
    tick(); tick();
    check("resume_pc", ir_pc, 2);

    // reset mid-stall
    ir_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ms_valid", ir_valid, 0);
    check("ms_ir", ir_out, 0);
    ir_ready = 1'b1;
    tick();
    check("ms_first", ir_pc, 0);

    // saturation
    for (int i = 0; i < 300; i++) tick();
    check("sat_count", fetch_count, 255);

    // randomized control with jumps in memory
    for (int i = 0; i < 16; i++) mem[i] = rand_word(1'b1);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) halt = ~halt;
      ir_ready       = ($urandom_range(0, 3) != 0);
      if (i % 500 == 499) mem[$urandom_range(0, 15)] = rand_word(1'b1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
